// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data SRAM between the CPU MEM stage and
// an external debug/loader master. One grant per cycle, winner muxed onto the
// SRAM port, 1-cycle read data tagged back to its owner.
//
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN
//   defined   - on conflict the requester not granted last wins (1-bit last_win)
//   undefined - CPU priority, ext forced a grant after STARVE_MAX denied cycles
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cpu_req/wen/addr/wdata       CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_stall           CPU grant this cycle, cpu_req & ~cpu_gnt
//   cpu_rvalid, cpu_rdata        CPU read return
//   ext_req/wen/addr/wdata       external request (held until ext_gnt)
//   ext_gnt                      external grant this cycle
//   ext_rvalid, ext_rdata        external read return
//   mem_addr/wen/ren/wdata       SRAM port drive
//   mem_rdata                    SRAM read data, valid 1 cycle after mem_ren
module dmem_arbiter #(
   parameter int unsigned ADDR_W     = 64,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_wen,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ext_req,
   input  logic              ext_wen,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [DATA_W-1:0] ext_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic              mem_ren,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // High when ext should win a conflict this cycle
   logic ext_prio;

   // Read-return tracking: rd_own 0 = cpu, 1 = ext
   logic rd_pend;
   logic rd_own;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   // Last winner: 0 = cpu, 1 = ext
   logic last_win;

   assign ext_prio = ~last_win;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_win <= 1'b0;
      end else if (cpu_gnt | ext_gnt) begin
         last_win <= ext_gnt;
      end
   end
`else
   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_cnt_nxt;

   assign ext_prio = (starve_cnt == CNT_W'(STARVE_MAX));

   // Count consecutive denied ext cycles, saturating; any grant or idle clears
   always_comb begin
      starve_cnt_nxt = '0;
      if (ext_req & ~ext_gnt) begin
         if (starve_cnt == CNT_W'(STARVE_MAX)) begin
            starve_cnt_nxt = starve_cnt;
         end else begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else begin
         starve_cnt <= starve_cnt_nxt;
      end
   end
`endif

   // Same-cycle grant; reset suppresses all grants
   always_comb begin
      cpu_gnt = 1'b0;
      ext_gnt = 1'b0;
      if (!rst) begin
         if (cpu_req & ext_req) begin
            ext_gnt = ext_prio;
            cpu_gnt = ~ext_prio;
         end else begin
            cpu_gnt = cpu_req;
            ext_gnt = ext_req;
         end
      end
   end

   assign cpu_stall = cpu_req & ~cpu_gnt;

   // Winner mux onto the SRAM port; idle port is driven to all zeros
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wen   = 1'b0;
      mem_ren   = 1'b0;
      if (cpu_gnt) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_wen   = cpu_wen;
         mem_ren   = ~cpu_wen;
      end else if (ext_gnt) begin
         mem_addr  = ext_addr;
         mem_wdata = ext_wdata;
         mem_wen   = ext_wen;
         mem_ren   = ~ext_wen;
      end
   end

   // Remember who owns the read issued this cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend <= 1'b0;
         rd_own  <= 1'b0;
      end else begin
         rd_pend <= (cpu_gnt & ~cpu_wen) | (ext_gnt & ~ext_wen);
         rd_own  <= ext_gnt;
      end
   end

   // rst gating drops a read whose data would land in a reset cycle
   assign cpu_rvalid = rd_pend & ~rd_own & ~rst;
   assign ext_rvalid = rd_pend & rd_own & ~rst;
   assign cpu_rdata  = mem_rdata;
   assign ext_rdata  = mem_rdata;

endmodule
